// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
// Match-level sequencer for the pong datapath. It owns the scores, the serve
// and freeze timing and the win detection. It tells the ball block when to
// hold, re-centre and run, and it tells the VGA mux which screen to draw.
//
// Optional feature: define PONG_PAUSE_EN to add a PAUSE state (code 5).
//   start in SERVE/RALLY parks the match in PAUSE, with the frame counter
//   frozen and misses ignored. A second start resumes the parked state.
//   Without the macro, start in SERVE/RALLY/POINT aborts to IDLE.
//
// Parameters
//   WIN_SCORE    points that end a match (1..15)
//   SERVE_FRAMES frames the ball sits centred before a serve (1..255)
//   POINT_FRAMES frames the field freezes after a point (1..255)
//   OVER_FRAMES  frames the winner screen is held (1..255)
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active high
//   i_start        debounced start press, one-cycle pulse
//   i_frame_tick   one-cycle pulse per video frame
//   i_miss_p1      ball passed p1's goal line (pulse)
//   i_miss_p2      ball passed p2's goal line (pulse)
//   o_ball_run     1 = ball may move
//   o_ball_center  one-cycle pulse: ball reloads centre position
//   o_serve_dir    0 = serve toward p1, 1 = serve toward p2
//   o_p1_score     player 1 score
//   o_p2_score     player 2 score
//   o_winner       00 none, 01 p1, 10 p2
//   o_title_on     1 = mux shows the start screen
//   o_state        current state code (debug)
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_frame_tick,
  input  logic       i_miss_p1,
  input  logic       i_miss_p2,
  output logic       o_ball_run,
  output logic       o_ball_center,
  output logic       o_serve_dir,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [1:0] o_winner,
  output logic       o_title_on,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
`ifdef PONG_PAUSE_EN
    , ST_PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [3:0] LP_WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] LP_POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [7:0] LP_OVER_LAST  = 8'(OVER_FRAMES - 1);

  state_t     r_state;
  logic [7:0] r_fc;
  logic [3:0] r_p1;
  logic [3:0] r_p2;
  logic [1:0] r_winner;
  logic       r_serve_dir;
  logic       r_ball_center;
  logic       r_ball_run;
  logic       r_title_on;

  state_t     w_state_next;
  logic [7:0] w_fc_next;
  logic [3:0] w_p1_next;
  logic [3:0] w_p2_next;
  logic [1:0] w_winner_next;
  logic       w_dir_next;
  logic       w_center_next;

`ifdef PONG_PAUSE_EN
  state_t     r_resume;
  state_t     w_resume_next;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_fc_next     = i_frame_tick ? (r_fc + 8'd1) : r_fc;
    w_p1_next     = r_p1;
    w_p2_next     = r_p2;
    w_winner_next = r_winner;
    w_dir_next    = r_serve_dir;
    w_center_next = 1'b0;
`ifdef PONG_PAUSE_EN
    w_resume_next = r_resume;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next  = ST_SERVE;
          w_p1_next     = 4'd0;
          w_p2_next     = 4'd0;
          w_winner_next = 2'b00;
          w_center_next = 1'b1;
        end
      end

      ST_SERVE: begin
        if (i_start) begin
`ifdef PONG_PAUSE_EN
          w_state_next  = ST_PAUSE;
          w_resume_next = ST_SERVE;
`else
          w_state_next  = ST_IDLE;
`endif
        end else if (i_frame_tick && (r_fc == LP_SERVE_LAST)) begin
          w_state_next = ST_RALLY;
        end
      end

      ST_RALLY: begin
        if (i_start) begin
`ifdef PONG_PAUSE_EN
          w_state_next  = ST_PAUSE;
          w_resume_next = ST_RALLY;
`else
          w_state_next  = ST_IDLE;
`endif
        end else if (i_miss_p1 && i_miss_p2) begin
          // Simultaneous misses: the point is void, nobody scores.
          w_state_next = ST_POINT;
        end else if (i_miss_p1) begin
          w_state_next = ST_POINT;
          w_dir_next   = 1'b0;
          w_p2_next    = (r_p2 < LP_WIN) ? (r_p2 + 4'd1) : r_p2;
        end else if (i_miss_p2) begin
          w_state_next = ST_POINT;
          w_dir_next   = 1'b1;
          w_p1_next    = (r_p1 < LP_WIN) ? (r_p1 + 4'd1) : r_p1;
        end
      end

      ST_POINT: begin
        if (i_start) begin
          w_state_next = ST_IDLE;
        end else if (i_frame_tick && (r_fc == LP_POINT_LAST)) begin
          if (r_p1 == LP_WIN) begin
            w_winner_next = 2'b01;
            w_state_next  = ST_OVER;
          end else if (r_p2 == LP_WIN) begin
            w_winner_next = 2'b10;
            w_state_next  = ST_OVER;
          end else begin
            w_center_next = 1'b1;
            w_state_next  = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
        if (i_start || (i_frame_tick && (r_fc == LP_OVER_LAST))) begin
          w_state_next = ST_IDLE;
        end
      end

`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        w_fc_next = r_fc;
        if (i_start) begin
          w_state_next = r_resume;
        end
      end
`endif

      default: w_state_next = ST_IDLE;
    endcase

    // Counter restarts on a genuine state change. Entering or leaving PAUSE
    // is not one: the parked state picks up its frame count where it stopped.
    if (w_state_next != r_state) begin
`ifdef PONG_PAUSE_EN
      if ((w_state_next != ST_PAUSE) && (r_state != ST_PAUSE)) begin
        w_fc_next = 8'd0;
      end
`else
      w_fc_next = 8'd0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_fc          <= 8'd0;
      r_p1          <= 4'd0;
      r_p2          <= 4'd0;
      r_winner      <= 2'b00;
      r_serve_dir   <= 1'b0;
      r_ball_center <= 1'b0;
      r_ball_run    <= 1'b0;
      r_title_on    <= 1'b1;
`ifdef PONG_PAUSE_EN
      r_resume      <= ST_SERVE;
`endif
    end else begin
      r_state       <= w_state_next;
      r_fc          <= w_fc_next;
      r_p1          <= w_p1_next;
      r_p2          <= w_p2_next;
      r_winner      <= w_winner_next;
      r_serve_dir   <= w_dir_next;
      r_ball_center <= w_center_next;
      // Decoded from the next state so the flags change on the same edge.
      r_ball_run    <= (w_state_next == ST_RALLY);
      r_title_on    <= (w_state_next == ST_IDLE);
`ifdef PONG_PAUSE_EN
      r_resume      <= w_resume_next;
`endif
    end
  end

  assign o_ball_run    = r_ball_run;
  assign o_ball_center = r_ball_center;
  assign o_serve_dir   = r_serve_dir;
  assign o_p1_score    = r_p1;
  assign o_p2_score    = r_p2;
  assign o_winner      = r_winner;
  assign o_title_on    = r_title_on;
  assign o_state       = r_state;

endmodule
